bird_cpu_param: RTL and testbench

//  Parametrised multicycle successor of the bird CPU: 16-bit instructions, 8-entry register

---
 rtl/bird_pkg.sv | 46 ++++
 rtl/bird_alu.sv | 44 ++++
 rtl/bird_cpu_param.sv | 164 ++++++++++++++++
 tb/tb_bird_cpu_param.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared definitions for the bird CPU: opcode values, FSM state encoding,
// ALU operation codes and unary sub-operation codes.
package bird_pkg;

    // Instruction opcodes (instruction word bits [15:12])
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_ALU  = 4'h7;
    localparam logic [3:0] OP_PUSH = 4'h8;
    localparam logic [3:0] OP_POP  = 4'h9;
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;

    typedef enum logic [3:0] {
        ST_FETCH = 4'd0,
        ST_LDI   = 4'd1,
        ST_LD    = 4'd2,
        ST_ST    = 4'd3,
        ST_JMP   = 4'd4,
        ST_ALU   = 4'd5,
        ST_PUSH  = 4'd6,
        ST_POP1  = 4'd7,
        ST_POP2  = 4'd8,
        ST_CALL  = 4'd9,
        ST_RET1  = 4'd10,
        ST_RET2  = 4'd11
    } state_t;

    // ALU operation (ir[11:9])
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_UNARY = 3'd7;

    // Unary sub-operation on B (ir[8:6], shares the A register field)
    localparam logic [2:0] UN_NOT  = 3'd0;
    localparam logic [2:0] UN_PASS = 3'd1;
    localparam logic [2:0] UN_INC  = 3'd2;
    localparam logic [2:0] UN_DEC  = 3'd3;

endpackage

// File: rtl/bird_alu.sv
// Combinational ALU of the bird CPU.
//   op     in   3   operation code
//   sub    in   3   unary sub-operation (used only when op = ALU_UNARY)
//   a, b   in   DW  operands
//   result out  DW  result, modulo 2^DW
//   zero   out  1   result == 0
module bird_alu
    import bird_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic [2:0]    op,
    input  logic [2:0]    sub,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero
);
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_UNARY: begin
                case (sub)
                    UN_NOT:  result = ~b;
                    UN_PASS: result = b;
                    UN_INC:  result = b + ONE;
                    UN_DEC:  result = b - ONE;
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/bird_cpu_param.sv
// bird_cpu_param: multicycle 16-bit-instruction CPU, 8 registers (R7 = SP),
// one memory access per state, every state waits for mem_ready.
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   data_in    in   DW  memory read data
//   mem_ready  in   1   current access completes this cycle
//   address    out  AW  memory address
//   data_out   out  DW  memory write data
//   memwt      out  1   1 = write access
//   state_dbg  out  4   FSM state
//   zero_flag  out  1   ALU zero flag
//
// state   | meaning
// FETCH   | read instruction at pc, decode, pc+1 (JZ not taken: pc+2)
// LDI     | read immediate at pc into R[D], pc+1
// LD      | read mem[R[B]] into R[D]
// ST      | write R[A] to mem[R[B]]
// JMP     | read offset at pc, pc = pc + offset
// ALU     | dummy read at pc, R[D] = ALU result, update zero_flag
// PUSH    | write R[A] to mem[SP], SP-1
// POP1    | dummy read at pc, SP+1
// POP2    | read mem[SP] into R[D]
// CALL    | write return address to mem[SP], SP-1, then JMP
// RET1    | dummy read at pc, SP+1
// RET2    | read mem[SP] into pc
module bird_cpu_param
    import bird_pkg::*;
#(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] SP_INIT  = 'hFFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          mem_ready,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data_out,
    output logic          memwt,
    output logic [3:0]    state_dbg,
    output logic          zero_flag
);
    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] D_ONE  = {{(DW-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic [11:0]   ir;
    logic [DW-1:0] regs [8];
    logic [2:0]    fld_a, fld_b, fld_d;
    logic [3:0]    opcode_in;
    logic [DW-1:0] sp, reg_a, reg_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic [DW-1:0] ret_addr;

    assign fld_a     = ir[8:6];
    assign fld_b     = ir[5:3];
    assign fld_d     = ir[2:0];
    assign opcode_in = data_in[15:12];
    assign sp        = regs[7];
    assign reg_a     = regs[fld_a];
    assign reg_b     = regs[fld_b];
    assign pc_inc    = pc + PC_ONE;
    // In CALL, pc points at the offset word; return lands just past it.
    assign ret_addr  = DW'(pc_inc);
    assign state_dbg = state;

    bird_alu #(.DW(DW)) u_alu (
        .op     (ir[11:9]),
        .sub    (fld_a),
        .a      (reg_a),
        .b      (reg_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            zero_flag <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                regs[i] <= '0;
            end
            regs[7] <= SP_INIT;
        end else if (mem_ready) begin
            state <= state_nxt;
            case (state)
                ST_FETCH: begin
                    ir <= data_in[11:0];
                    // Not-taken JZ steps over its offset word as well.
                    if (opcode_in == OP_JZ && !zero_flag) begin
                        pc <= pc_inc + PC_ONE;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                ST_LDI: begin
                    regs[fld_d] <= data_in;
                    pc          <= pc_inc;
                end
                ST_LD, ST_POP2: regs[fld_d] <= data_in;
                ST_JMP:  pc <= pc + data_in[AW-1:0];
                ST_ALU: begin
                    regs[fld_d] <= alu_result;
                    zero_flag   <= alu_zero;
                end
                ST_PUSH, ST_CALL: regs[7] <= sp - D_ONE;
                ST_POP1, ST_RET1: regs[7] <= sp + D_ONE;
                ST_RET2: pc <= data_in[AW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = ST_FETCH;
        address   = pc;
        memwt     = 1'b0;
        data_out  = reg_a;
        case (state)
            ST_FETCH: begin
                case (opcode_in)
                    OP_LDI:  state_nxt = ST_LDI;
                    OP_LD:   state_nxt = ST_LD;
                    OP_ST:   state_nxt = ST_ST;
                    OP_JZ:   state_nxt = zero_flag ? ST_JMP : ST_FETCH;
                    OP_JMP:  state_nxt = ST_JMP;
                    OP_ALU:  state_nxt = ST_ALU;
                    OP_PUSH: state_nxt = ST_PUSH;
                    OP_POP:  state_nxt = ST_POP1;
                    OP_CALL: state_nxt = ST_CALL;
                    OP_RET:  state_nxt = ST_RET1;
                    default: state_nxt = ST_FETCH;
                endcase
            end
            ST_LD: address = reg_b[AW-1:0];
            ST_ST: begin
                address = reg_b[AW-1:0];
                memwt   = 1'b1;
            end
            ST_PUSH: begin
                address = sp[AW-1:0];
                memwt   = 1'b1;
            end
            ST_POP1: state_nxt = ST_POP2;
            ST_POP2: address = sp[AW-1:0];
            ST_CALL: begin
                address   = sp[AW-1:0];
                memwt     = 1'b1;
                data_out  = ret_addr;
                state_nxt = ST_JMP;
            end
            ST_RET1: state_nxt = ST_RET2;
            ST_RET2: address = sp[AW-1:0];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bird_cpu_param.sv
// Self-checking bench for bird_cpu_param (default DW=AW=16, RESET_PC=0, SP_INIT=FFFF).
module tb_bird_cpu_param;
    import bird_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        mem_ready;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        memwt;
    logic [3:0]  state_dbg;
    logic        zero_flag;

    logic [15:0] mem [65536];
    logic [15:0] mm  [65536];
    logic [15:0] mr  [8];
    logic [15:0] mpc;
    logic        mz;

    int          checks;
    int          failures;
    int unsigned stall_pct;
    bit          force_stall;
    int          wp;

    assign data_in = mem[address];

    bird_cpu_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .mem_ready (mem_ready),
        .address   (address),
        .data_out  (data_out),
        .memwt     (memwt),
        .state_dbg (state_dbg),
        .zero_flag (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [2:0]  af;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
    } alu_vec_t;

    alu_vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] f,
                                        input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] d);
        return {op, f, a, b, d};
    endfunction

    function automatic logic [15:0] i_ldi(input logic [2:0] d);  return enc(4'h1, 3'd0, 3'd0, 3'd0, d); endfunction
    function automatic logic [15:0] i_ld(input logic [2:0] b, input logic [2:0] d); return enc(4'h2, 3'd0, 3'd0, b, d); endfunction
    function automatic logic [15:0] i_st(input logic [2:0] a, input logic [2:0] b); return enc(4'h3, 3'd0, a, b, 3'd0); endfunction
    function automatic logic [15:0] i_alu(input logic [2:0] f, input logic [2:0] a,
                                          input logic [2:0] b, input logic [2:0] d);
        return enc(4'h7, f, a, b, d);
    endfunction
    function automatic logic [15:0] i_push(input logic [2:0] a); return enc(4'h8, 3'd0, a, 3'd0, 3'd0); endfunction
    function automatic logic [15:0] i_pop(input logic [2:0] d);  return enc(4'h9, 3'd0, 3'd0, 3'd0, d); endfunction

    localparam logic [15:0] I_JZ   = 16'h4000;
    localparam logic [15:0] I_JMP  = 16'h5000;
    localparam logic [15:0] I_CALL = 16'hA000;
    localparam logic [15:0] I_RET  = 16'hB000;

    task automatic emit(input logic [15:0] w);
        mem[wp] = w;
        wp++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        wp = 0;
    endtask

    // One clock cycle: choose mem_ready at the falling edge, capture any write
    // request, apply it to memory just after the rising edge.
    task automatic tick();
        logic        wr;
        logic [15:0] wa, wd;
        @(negedge clk);
        mem_ready = force_stall ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
        #1;
        wr = memwt & mem_ready;
        wa = address;
        wd = data_out;
        @(posedge clk);
        #1;
        if (wr) mem[wa] = wd;
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_fetch(input logic [15:0] target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (state_dbg == 4'(ST_FETCH) && address == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] f, input logic [2:0] s,
                                            input logic [15:0] a, input logic [15:0] b);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd7: begin
                case (s)
                    3'd0: return ~b;
                    3'd1: return b;
                    3'd2: return b + 16'd1;
                    3'd3: return b - 16'd1;
                    default: return 16'h0000;
                endcase
            end
            default: return 16'h0000;
        endcase
    endfunction

    // Instruction-level interpreter over mm[], zero wait states.
    task automatic model_run(input logic [15:0] halt, output bit ok);
        logic [15:0] w, t;
        logic [2:0]  a, b, d;
        mpc = 16'h0000;
        for (int i = 0; i < 7; i++) mr[i] = 16'h0000;
        mr[7] = 16'hFFFF;
        mz    = 1'b0;
        ok    = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (mpc == halt) begin
                ok = 1'b1;
                break;
            end
            w   = mm[mpc];
            mpc = mpc + 16'd1;
            a = w[8:6]; b = w[5:3]; d = w[2:0];
            case (w[15:12])
                4'h1: begin mr[d] = mm[mpc]; mpc = mpc + 16'd1; end
                4'h2: mr[d] = mm[mr[b]];
                4'h3: mm[mr[b]] = mr[a];
                4'h4: if (mz) mpc = mpc + mm[mpc]; else mpc = mpc + 16'd1;
                4'h5: mpc = mpc + mm[mpc];
                4'h7: begin t = alu_ref(w[11:9], a, mr[a], mr[b]); mr[d] = t; mz = (t == 16'h0000); end
                4'h8: begin mm[mr[7]] = mr[a]; mr[7] = mr[7] - 16'd1; end
                4'h9: begin mr[7] = mr[7] + 16'd1; mr[d] = mm[mr[7]]; end
                4'hA: begin mm[mr[7]] = mpc + 16'd1; mr[7] = mr[7] - 16'd1; mpc = mpc + mm[mpc]; end
                4'hB: begin mr[7] = mr[7] + 16'd1; mpc = mm[mr[7]]; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [2:0] r_dst();  return 3'($urandom_range(0, 4)); endfunction
    function automatic logic [2:0] r_any();  return 3'($urandom_range(0, 7)); endfunction
    function automatic logic [2:0] r_addr(); return ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6; endfunction

    task automatic gen_program(output logic [15:0] halt);
        int k;
        clear_mem();
        for (int i = 0; i < 256; i++) mem[16'h0400 + i] = 16'($urandom);
        emit(i_ldi(3'd7)); emit(16'h07FF);
        emit(i_ldi(3'd5)); emit(16'h0400 + 16'($urandom_range(0, 255)));
        emit(i_ldi(3'd6)); emit(16'h0400 + 16'($urandom_range(0, 255)));
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: begin emit(i_ldi(r_dst())); emit(16'($urandom)); end
                1: begin emit(i_ldi(r_addr())); emit(16'h0400 + 16'($urandom_range(0, 255))); end
                2: emit(i_ld(r_addr(), r_dst()));
                3: emit(i_st(r_any(), r_addr()));
                4, 5: emit(i_alu(r_any(), r_any(), r_any(), r_dst()));
                6: emit(i_push(r_any()));
                7: emit(i_pop(r_dst()));
                8: begin
                    // JZ/JMP over exactly one single-word ALU instruction
                    emit(($urandom_range(0, 1) == 0) ? I_JZ : I_JMP);
                    emit(16'h0002);
                    emit(i_alu(r_any(), r_any(), r_any(), r_dst()));
                end
                default: begin
                    if ($urandom_range(0, 2) == 0) emit({4'h0, 12'($urandom)});
                    else if ($urandom_range(0, 1) == 0) emit({4'h6, 12'($urandom)});
                    else emit({4'($urandom_range(12, 15)), 12'($urandom)});
                end
            endcase
        end
        emit(i_ldi(3'd7)); emit(16'h0900);
        for (int i = 0; i < 7; i++) emit(i_push(3'(i)));
        halt = 16'(wp);
        emit(I_JMP); emit(16'hFFFF);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit          ok, mok;
        logic [15:0] halt;
        int          diffs, first;

        checks = 0; failures = 0;
        stall_pct = 0; force_stall = 1'b0;
        rst_n = 1'b0; mem_ready = 1'b0;

        vt[0]  = '{3'd0, 3'd1, 16'h0005, 16'h0005, 16'h000A, 1'b0};
        vt[1]  = '{3'd1, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1};
        vt[2]  = '{3'd1, 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
        vt[3]  = '{3'd0, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vt[4]  = '{3'd2, 3'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
        vt[5]  = '{3'd3, 3'd1, 16'hF000, 16'h000F, 16'hF00F, 1'b0};
        vt[6]  = '{3'd4, 3'd1, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1};
        vt[7]  = '{3'd4, 3'd1, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        vt[8]  = '{3'd5, 3'd1, 16'h0001, 16'h0002, 16'h0000, 1'b1};
        vt[9]  = '{3'd6, 3'd1, 16'h0001, 16'h0002, 16'h0000, 1'b1};
        vt[10] = '{3'd7, 3'd0, 16'h0000, 16'h00FF, 16'hFF00, 1'b0};
        vt[11] = '{3'd7, 3'd1, 16'h0000, 16'h1234, 16'h1234, 1'b0};
        vt[12] = '{3'd7, 3'd2, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
        vt[13] = '{3'd7, 3'd3, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        vt[14] = '{3'd7, 3'd4, 16'h0000, 16'h0005, 16'h0000, 1'b1};
        vt[15] = '{3'd7, 3'd7, 16'h0000, 16'h0005, 16'h0000, 1'b1};

        // Reset values, then reset during a stalled ST
        clear_mem();
        emit(i_st(3'd0, 3'd0));
        do_reset();
        check("rst_state", state_dbg, 4'(ST_FETCH));
        check("rst_address", address, 16'h0000);
        check("rst_memwt", memwt, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_zero_flag", zero_flag, 1'b0);
        tick();
        check("st_state", state_dbg, 4'(ST_ST));
        check("st_memwt", memwt, 1'b1);
        force_stall = 1'b1;
        tick();
        check("st_stall_memwt", memwt, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_memwt", memwt, 1'b0);
        check("async_rst_state", state_dbg, 4'(ST_FETCH));
        check("async_rst_address", address, 16'h0000);
        tick();
        check("rst_next_state", state_dbg, 4'(ST_FETCH));
        check("st_abandoned", mem[0], 16'h3000);
        force_stall = 1'b0;

        // Table-driven ALU vectors
        stall_pct = 20;
        for (int v = 0; v < 16; v++) begin
            clear_mem();
            emit(i_ldi(3'd1)); emit(vt[v].a);
            emit(i_ldi(3'd2)); emit(vt[v].b);
            emit(i_ldi(3'd5)); emit(16'h0100);
            emit(i_alu(vt[v].f, vt[v].af, 3'd2, 3'd3));
            emit(i_st(3'd3, 3'd5));
            emit(I_JMP); emit(16'hFFFF);
            do_reset();
            run_until_fetch(16'h0008, 300, ok);
            check($sformatf("alu%0d_halt", v), ok, 1'b1);
            check($sformatf("alu%0d_result", v), mem[16'h0100], vt[v].res);
            check($sformatf("alu%0d_zero", v), zero_flag, vt[v].z);
        end
        stall_pct = 0;

        // JZ taken after SUB gives zero
        clear_mem();
        emit(i_ldi(3'd1)); emit(16'h0005);
        emit(i_ldi(3'd2)); emit(16'h0005);
        emit(i_alu(3'd1, 3'd1, 3'd2, 3'd3));
        emit(I_JZ); emit(16'h0004);
        emit(16'hF000); emit(16'hF000); emit(16'hF000);
        emit(I_JMP); emit(16'hFFFF);
        do_reset();
        run_until_fetch(16'h0005, 100, ok);
        check("jz_t_reach", ok, 1'b1);
        check("jz_t_zero", zero_flag, 1'b1);
        tick();
        check("jz_t_state", state_dbg, 4'(ST_JMP));
        check("jz_t_offaddr", address, 16'h0006);
        tick();
        check("jz_t_target_state", state_dbg, 4'(ST_FETCH));
        check("jz_t_target", address, 16'h000A);

        // JZ not taken at pc=10
        clear_mem();
        emit(i_ldi(3'd1)); emit(16'h0001);
        emit(i_ldi(3'd2)); emit(16'h0000);
        emit(i_alu(3'd0, 3'd1, 3'd2, 3'd3));
        for (int i = 0; i < 5; i++) emit(16'h0000);
        emit(I_JZ); emit(16'h0005);
        emit(I_JMP); emit(16'hFFFF);
        do_reset();
        run_until_fetch(16'h000A, 100, ok);
        check("jz_nt_reach", ok, 1'b1);
        check("jz_nt_zero", zero_flag, 1'b0);
        tick();
        check("jz_nt_state", state_dbg, 4'(ST_FETCH));
        check("jz_nt_next", address, 16'h000C);

        // PUSH / POP around SP=0xFF
        clear_mem();
        emit(i_ldi(3'd7)); emit(16'h00FF);
        emit(i_ldi(3'd1)); emit(16'hAAAA);
        emit(i_ldi(3'd5)); emit(16'h0100);
        emit(i_push(3'd1));
        emit(i_pop(3'd4));
        emit(i_st(3'd4, 3'd5));
        emit(i_push(3'd7));
        emit(I_JMP); emit(16'hFFFF);
        do_reset();
        run_until_fetch(16'h0006, 100, ok);
        check("push_reach", ok, 1'b1);
        tick();
        check("push_state", state_dbg, 4'(ST_PUSH));
        check("push_addr", address, 16'h00FF);
        check("push_memwt", memwt, 1'b1);
        check("push_data", data_out, 16'hAAAA);
        tick();
        check("push_mem", mem[16'h00FF], 16'hAAAA);
        tick();
        tick();
        check("pop2_state", state_dbg, 4'(ST_POP2));
        check("pop2_addr", address, 16'h00FF);
        run_until_fetch(16'h000A, 100, ok);
        check("pop_reach", ok, 1'b1);
        check("pop_value", mem[16'h0100], 16'hAAAA);
        check("pop_sp", mem[16'h00FF], 16'h00FF);

        // CALL at 0x20, RET back to 0x22
        clear_mem();
        emit(i_ldi(3'd7)); emit(16'h0080);
        emit(I_JMP); emit(16'h001D);
        wp = 16'h20;
        emit(I_CALL); emit(16'h0010);
        emit(i_ldi(3'd5)); emit(16'h0100);
        emit(i_alu(3'd7, 3'd1, 3'd7, 3'd3));
        emit(i_st(3'd3, 3'd5));
        emit(I_JMP); emit(16'hFFFF);
        wp = 16'h31;
        emit(I_RET);
        do_reset();
        run_until_fetch(16'h0020, 100, ok);
        check("call_reach", ok, 1'b1);
        tick();
        check("call_state", state_dbg, 4'(ST_CALL));
        check("call_addr", address, 16'h0080);
        check("call_memwt", memwt, 1'b1);
        check("call_data", data_out, 16'h0022);
        tick();
        check("call_jmp_addr", address, 16'h0021);
        tick();
        check("call_target", address, 16'h0031);
        check("call_mem", mem[16'h0080], 16'h0022);
        run_until_fetch(16'h0022, 100, ok);
        check("ret_reach", ok, 1'b1);
        run_until_fetch(16'h0026, 100, ok);
        check("ret_done", ok, 1'b1);
        check("ret_sp", mem[16'h0100], 16'h0080);

        // Forced stalls in FETCH and LD
        clear_mem();
        emit(i_ldi(3'd5)); emit(16'h0100);
        emit(i_ldi(3'd6)); emit(16'h0101);
        emit(i_ld(3'd5, 3'd2));
        emit(i_st(3'd2, 3'd6));
        emit(I_JMP); emit(16'hFFFF);
        mem[16'h0100] = 16'h5A5A;
        do_reset();
        run_until_fetch(16'h0004, 100, ok);
        check("stall_reach", ok, 1'b1);
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_fetch_state", state_dbg, 4'(ST_FETCH));
            check("stall_fetch_addr", address, 16'h0004);
        end
        force_stall = 1'b0;
        tick();
        check("ld_state", state_dbg, 4'(ST_LD));
        check("ld_addr", address, 16'h0100);
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ld_state", state_dbg, 4'(ST_LD));
            check("stall_ld_addr", address, 16'h0100);
            check("stall_ld_memwt", memwt, 1'b0);
        end
        force_stall = 1'b0;
        tick();
        check("ld_next", address, 16'h0005);
        run_until_fetch(16'h0006, 100, ok);
        check("ld_done", ok, 1'b1);
        check("ld_value", mem[16'h0101], 16'h5A5A);

        // Random programs with random wait states against the model
        for (int r = 0; r < 3; r++) begin
            gen_program(halt);
            for (int i = 0; i < 65536; i++) mm[i] = mem[i];
            model_run(halt, mok);
            check("rand_model_halt", mok, 1'b1);
            stall_pct = 30 * r;
            do_reset();
            run_until_fetch(halt, 8000, ok);
            check("rand_dut_halt", ok, 1'b1);
            diffs = 0;
            first = -1;
            for (int i = 0; i < 65536; i++) begin
                if (mem[i] !== mm[i]) begin
                    if (diffs == 0) first = i;
                    diffs++;
                end
            end
            check("rand_mem_diffs", diffs, 0);
            if (diffs != 0)
                $display("  first difference at %0h dut=%0h model=%0h", first, mem[first], mm[first]);
            check("rand_zero_flag", zero_flag, mz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
